cache_axi_txn_tracker: RTL

// - Sits directly downstream of the cache subsystem AXI/ACE master port, between it and the SoC interconnect.
// - Classifies every AR/AW by ID class: I$ 4'b0000, bypass 4'b10xx, D$ 4'b1100; other IDs are class ILLEGAL.
// - Tracks outstanding reads/writes per class and throttles new requests at a per-class limit.
// - Flags protocol errors and, optionally, hung transactions.

---
 rtl/cache_axi_txn_tracker_pkg.sv | 78 +++++++
 rtl/cache_axi_txn_tracker_counter.sv | 33 +++
 rtl/cache_axi_txn_tracker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cache_axi_txn_tracker_pkg.sv
// Shared types for the cache AXI transaction tracker: ID classes, AXI/ACE channel structs, ID decoder.
// Latency: none; types and pure functions only.
// Backpressure: not applicable.
package cache_axi_txn_tracker_pkg;

    localparam int IdW   = 4;
    localparam int AddrW = 32;
    localparam int DataW = 64;

    // Cache-subsystem ID map: I$ owns one ID, D$ owns one ID, bypass owns the 10xx block
    localparam logic [IdW-1:0] ID_ICACHE     = 4'b0000;
    localparam logic [1:0]     ID_BYPASS_PFX = 2'b10;
    localparam logic [IdW-1:0] ID_DCACHE     = 4'b1100;

    // Encoding doubles as the counter index: [0]=D$, [1]=bypass, [2]=I$
    typedef enum logic [1:0] {
        CLS_DCACHE  = 2'd0,
        CLS_BYPASS  = 2'd1,
        CLS_ICACHE  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } txn_class_e;

    localparam int NumCls = 3;
    localparam int CntW   = 4;

    typedef struct packed {
        logic [IdW-1:0]     aw_id;
        logic [AddrW-1:0]   aw_addr;
        logic [7:0]         aw_len;
        logic               aw_valid;
        logic [DataW-1:0]   w_data;
        logic [DataW/8-1:0] w_strb;
        logic               w_last;
        logic               w_valid;
        logic               b_ready;
        logic [IdW-1:0]     ar_id;
        logic [AddrW-1:0]   ar_addr;
        logic [7:0]         ar_len;
        logic               ar_valid;
        logic               r_ready;
        logic               ac_ready;
        logic [4:0]         cr_resp;
        logic               cr_valid;
        logic [DataW-1:0]   cd_data;
        logic               cd_last;
        logic               cd_valid;
    } axi_req_t;

    typedef struct packed {
        logic               aw_ready;
        logic               ar_ready;
        logic               w_ready;
        logic [IdW-1:0]     b_id;
        logic [1:0]         b_resp;
        logic               b_valid;
        logic [IdW-1:0]     r_id;
        logic [DataW-1:0]   r_data;
        logic [1:0]         r_resp;
        logic               r_last;
        logic               r_valid;
        logic [AddrW-1:0]   ac_addr;
        logic [3:0]         ac_snoop;
        logic               ac_valid;
        logic               cr_ready;
        logic               cd_ready;
    } axi_rsp_t;

    localparam int ReqW = $bits(axi_req_t);
    localparam int RspW = $bits(axi_rsp_t);

    function automatic txn_class_e id_to_class(input logic [IdW-1:0] id);
        if (id == ID_ICACHE)                  return CLS_ICACHE;
        if (id[IdW-1 -: 2] == ID_BYPASS_PFX)  return CLS_BYPASS;
        if (id == ID_DCACHE)                  return CLS_DCACHE;
        return CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/cache_axi_txn_tracker_counter.sv
// One outstanding-transaction counter: saturating up/down with an underflow indication.
// Latency: count updates one cycle after inc/dec; below_max and underflow are combinational.
// Backpressure: none itself; the owner gates requests with below_max so inc never meets a full counter.
module axi_txn_class_counter
    import cache_axi_txn_tracker_pkg::*;
#(
    parameter int MaxCount = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc,
    input  logic            dec,
    output logic [CntW-1:0] cnt,
    output logic            below_max,
    output logic            underflow
);

    assign below_max = (cnt < CntW'(MaxCount));
    // A response with nothing outstanding; a simultaneous request cancels it out
    assign underflow = dec & ~inc & (cnt == '0);

    // Count requests up and completions down; simultaneous inc/dec leaves the count unchanged
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (inc && !dec && below_max) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/cache_axi_txn_tracker.sv
// Tracks outstanding AR/AW per cache ID class, throttles each class at MaxOutstanding, flags protocol errors (watchdog with CACHE_AXI_TIMEOUT_EN).
// Latency: zero-cycle combinational pass-through on every channel; status flags register one cycle after the event.
// Backpressure: only ar/aw valid and ready are masked when the class counter is full; illegal IDs are never masked.
module cache_axi_txn_tracker
    import cache_axi_txn_tracker_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [ReqW-1:0]        slv_req_i,
    output logic [RspW-1:0]        slv_resp_o,
    output logic [ReqW-1:0]        mst_req_o,
    input  logic [RspW-1:0]        mst_resp_i,
    input  logic                   clear_i,
    output logic                   busy_o,
    output logic [NumCls*CntW-1:0] rd_cnt_o,
    output logic [NumCls*CntW-1:0] wr_cnt_o,
    output logic                   err_o,
    output logic                   timeout_o
);

    axi_req_t slv_req;
    axi_req_t mst_req;
    axi_rsp_t mst_rsp;
    axi_rsp_t slv_rsp;

    assign slv_req    = slv_req_i;
    assign mst_rsp    = mst_resp_i;
    assign mst_req_o  = mst_req;
    assign slv_resp_o = slv_rsp;

    txn_class_e ar_cls, aw_cls, r_cls, b_cls;
    logic [3:0] ar_oh, aw_oh, r_oh, b_oh;

    assign ar_cls = id_to_class(slv_req.ar_id);
    assign aw_cls = id_to_class(slv_req.aw_id);
    assign r_cls  = id_to_class(mst_rsp.r_id);
    assign b_cls  = id_to_class(mst_rsp.b_id);

    assign ar_oh = 4'b0001 << ar_cls;
    assign aw_oh = 4'b0001 << aw_cls;
    assign r_oh  = 4'b0001 << r_cls;
    assign b_oh  = 4'b0001 << b_cls;

    logic [NumCls-1:0][CntW-1:0] rd_cnt, wr_cnt;
    logic [NumCls-1:0]           rd_below, wr_below, rd_uflow, wr_uflow;
    logic [NumCls-1:0]           rd_inc, rd_dec, wr_inc, wr_dec;
    logic                        ar_ok, aw_ok;
    logic                        ar_hs, aw_hs, r_last_hs, b_hs;

    // Index 3 is the illegal class, which is never throttled
    assign ar_ok = |(ar_oh & {1'b1, rd_below});
    assign aw_ok = |(aw_oh & {1'b1, wr_below});

    // Pass every channel straight through, masking only the address-channel handshake of full classes
    always_comb begin
        mst_req          = slv_req;
        mst_req.ar_valid = slv_req.ar_valid & ar_ok;
        mst_req.aw_valid = slv_req.aw_valid & aw_ok;
        slv_rsp          = mst_rsp;
        slv_rsp.ar_ready = mst_rsp.ar_ready & ar_ok;
        slv_rsp.aw_ready = mst_rsp.aw_ready & aw_ok;
    end

    assign ar_hs     = mst_req.ar_valid & mst_rsp.ar_ready;
    assign aw_hs     = mst_req.aw_valid & mst_rsp.aw_ready;
    assign r_last_hs = mst_rsp.r_valid & slv_req.r_ready & mst_rsp.r_last;
    assign b_hs      = mst_rsp.b_valid & slv_req.b_ready;

    assign rd_inc = ar_oh[NumCls-1:0] & {NumCls{ar_hs}};
    assign rd_dec = r_oh[NumCls-1:0]  & {NumCls{r_last_hs}};
    assign wr_inc = aw_oh[NumCls-1:0] & {NumCls{aw_hs}};
    assign wr_dec = b_oh[NumCls-1:0]  & {NumCls{b_hs}};

    for (genvar i = 0; i < NumCls; i++) begin : g_cls
        axi_txn_class_counter #(.MaxCount(MaxOutstanding)) u_rd_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc       (rd_inc[i]),
            .dec       (rd_dec[i]),
            .cnt       (rd_cnt[i]),
            .below_max (rd_below[i]),
            .underflow (rd_uflow[i])
        );
        axi_txn_class_counter #(.MaxCount(MaxOutstanding)) u_wr_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc       (wr_inc[i]),
            .dec       (wr_dec[i]),
            .cnt       (wr_cnt[i]),
            .below_max (wr_below[i]),
            .underflow (wr_uflow[i])
        );
    end

    assign rd_cnt_o = rd_cnt;
    assign wr_cnt_o = wr_cnt;
    assign busy_o   = (|rd_cnt) | (|wr_cnt);

    // Illegal IDs on any channel, or completions with nothing outstanding
    logic err_evt;
    logic err_q;

    assign err_evt = (|rd_uflow) | (|wr_uflow)
                   | (ar_hs & ar_oh[3]) | (aw_hs & aw_oh[3])
                   | (r_last_hs & r_oh[3]) | (b_hs & b_oh[3]);

    // Sticky error flag; a new error in the clearing cycle keeps it set
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (clear_i) begin
            err_q <= err_evt;
        end else begin
            err_q <= err_q | err_evt;
        end
    end

    assign err_o = err_q;

`ifdef CACHE_AXI_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);

    logic [WdW-1:0] wd_cnt;
    logic           wd_hit;
    logic           timeout_q;

    assign wd_hit = (wd_cnt == WdW'(TimeoutCycles));

    // Count busy cycles without forward progress; saturate at the threshold
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
        end else if (!busy_o || r_last_hs || b_hs) begin
            wd_cnt <= '0;
        end else if (!wd_hit) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky hung-transaction flag with the same clear/set priority as err_o
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (clear_i) begin
            timeout_q <= wd_hit;
        end else begin
            timeout_q <= timeout_q | wd_hit;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
